// File: rtl/du_rx_loader.sv
// ============================================================================
// du_rx_loader: assembles UART bytes into the instruction count, 32-bit
// instruction words with memory write strobes, and operation-mode bytes.
// Rev 1.0
// ============================================================================
`default_nettype none

module du_rx_loader #(
    parameter int N_BITS  = 8,
    parameter int NB_DATA = 32,
    parameter int N_BYTES = 4,
    parameter int ADDR_W  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [N_BITS-1:0]  i_rx_data,
    input  logic               i_mode_en,
    output logic [N_BITS-1:0]  o_number_instructions,
    output logic               o_ready_number_instr,
    output logic [NB_DATA-1:0] o_instruction,
    output logic               o_ready_full_inst,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [ADDR_W-1:0]  o_addr_instruction,
    output logic               o_ready_all_instr_send,
    output logic [N_BITS-1:0]  o_mode_operate,
    output logic               o_ready_mode_operate,
    output logic [3:0]         o_state
);

    localparam int         CNT_W   = $clog2(N_BYTES);
    localparam logic [3:0] S_COUNT = 4'b0001;
    localparam logic [3:0] S_LOAD  = 4'b0010;
    localparam logic [3:0] S_DONE  = 4'b0100;
    localparam logic [3:0] S_MODE  = 4'b1000;

    logic [3:0]         state;
    logic [3:0]         next_state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [NB_DATA-1:0] shift_reg;

    logic               take_count;
    logic               take_byte;
    logic               word_done;
    logic               last_word;
    logic               take_mode;
    logic [ADDR_W-1:0]  addr_next;
    logic [NB_DATA-1:0] assembled;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_COUNT;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_COUNT: if (i_rx_done)
                         next_state = (i_rx_data == '0) ? S_MODE : S_LOAD;
            S_LOAD:  if (last_word) next_state = S_DONE;
            S_DONE:  next_state = S_MODE;
            S_MODE:  next_state = S_MODE;
            default: next_state = S_COUNT;
        endcase
    end

    // Output/decode logic
    always_comb begin
        take_count = (state == S_COUNT) && i_rx_done;
        take_byte  = (state == S_LOAD) && i_rx_done;
        take_mode  = (state == S_MODE) && i_rx_done && i_mode_en;
        word_done  = take_byte && (byte_cnt == CNT_W'(N_BYTES - 1));
        addr_next  = o_addr_instruction + ADDR_W'(1);
        last_word  = word_done && (addr_next == ADDR_W'(o_number_instructions));
        // Little-endian: each new byte enters at the top and older bytes slide down.
        assembled  = {i_rx_data, shift_reg[NB_DATA-1:N_BITS]};
        o_state    = state;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_number_instructions  <= '0;
            o_ready_number_instr   <= 1'b0;
            o_instruction          <= '0;
            o_ready_full_inst      <= 1'b0;
            o_wr_en                <= 1'b0;
            o_wr_addr              <= '0;
            o_addr_instruction     <= '0;
            o_ready_all_instr_send <= 1'b0;
            o_mode_operate         <= '0;
            o_ready_mode_operate   <= 1'b0;
            byte_cnt               <= '0;
            shift_reg              <= '0;
        end else begin
            o_ready_number_instr <= 1'b0;
            o_ready_full_inst    <= 1'b0;
            o_wr_en              <= 1'b0;
            o_ready_mode_operate <= 1'b0;

            if (take_count) begin
                o_number_instructions <= i_rx_data;
                o_ready_number_instr  <= 1'b1;
                if (i_rx_data == '0) o_ready_all_instr_send <= 1'b1;
            end

            if (take_byte) begin
                shift_reg <= assembled;
                byte_cnt  <= word_done ? '0 : byte_cnt + CNT_W'(1);
            end

            if (word_done) begin
                o_instruction      <= assembled;
                o_ready_full_inst  <= 1'b1;
                o_wr_en            <= 1'b1;
                o_wr_addr          <= o_addr_instruction;
                o_addr_instruction <= addr_next;
            end

            if (state == S_DONE) o_ready_all_instr_send <= 1'b1;

            if (take_mode) begin
                o_mode_operate       <= i_rx_data;
                o_ready_mode_operate <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
